// File: rtl/pipe_mux.sv
// N-way registered stream multiplexer with valid/ready on every channel.
// Round-robin source selection is built only when PIPE_MUX_RR_EN is defined.
module pipe_mux #(
    parameter int N     = 4,
    parameter int WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         mode,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0] sel,
    input  logic [N*WIDTH-1:0]           in_data,
    input  logic [N-1:0]                 in_valid,
    output logic [N-1:0]                 in_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] out_chan
);

    localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] out_chan_q, out_chan_d;

    logic             free;
    logic             load;
    logic             grant_valid;
    logic [SEL_W-1:0] grant_idx;

    // Explicit-mode grant: the selected channel, if it exists and is valid.
    logic             ex_valid;
    logic             sel_ok;

    assign free   = !out_valid_q || out_ready;
    assign sel_ok = (int'(sel) < N);

    always_comb begin
        ex_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (sel_ok && (i == int'(sel)) && in_valid[i]) begin
                ex_valid = 1'b1;
            end
        end
    end

`ifdef PIPE_MUX_RR_EN
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             rr_valid;
    logic [SEL_W-1:0] rr_idx;

    // Search starts one past the last winner and wraps, so ptr = N-1 favours channel 0.
    always_comb begin
        int idx;
        rr_valid = 1'b0;
        rr_idx   = '0;
        idx      = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr_q) + k) % N;
            if (!rr_valid && in_valid[idx]) begin
                rr_valid = 1'b1;
                rr_idx   = SEL_W'(idx);
            end
        end
    end

    always_comb begin
        grant_valid = mode ? rr_valid : ex_valid;
        grant_idx   = mode ? rr_idx   : sel;
        in_ready    = '0;
        for (int i = 0; i < N; i++) begin
            if (mode) begin
                in_ready[i] = free && rr_valid && (i == int'(rr_idx));
            end else begin
                in_ready[i] = free && sel_ok && (i == int'(sel));
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (load && mode) begin
            ptr_d = rr_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= SEL_W'(N - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    logic unused_mode;
    assign unused_mode = mode;

    always_comb begin
        grant_valid = ex_valid;
        grant_idx   = sel;
        in_ready    = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = free && sel_ok && (i == int'(sel));
        end
    end
`endif

    assign load = free && grant_valid;

    // Output register: load replaces the word, a drain without load only clears valid.
    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        if (load) begin
            out_data_d  = in_data[int'(grant_idx)*WIDTH +: WIDTH];
            out_chan_d  = grant_idx;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_chan  = out_chan_q;

endmodule
